// File: rtl/stream_accum.sv
// Streaming reducer: after a start command, accepts n samples over valid/ready
// and reduces them (wrap sum, saturating sum, min, max) to one held result.
module stream_accum #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8,
    parameter int SUM_W  = 16,
    parameter bit SIGNED = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  n_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [SUM_W-1:0]  result_o,
    output logic              overflow_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] M_WRAP = 2'd0;
    localparam logic [1:0] M_MIN  = 2'd1;
    localparam logic [1:0] M_MAX  = 2'd2;
    localparam logic [1:0] M_SAT  = 2'd3;

    logic [1:0]        state, state_nxt;
    logic [CNT_W-1:0]  n_q, cnt;
    logic [1:0]        mode_q;
    logic [SUM_W-1:0]  acc, acc_nxt;
    logic              ovf_q, ovf_nxt;

    logic [SUM_W-1:0]        ext;
    logic signed [SUM_W-1:0] ext_s, acc_s;
    logic [SUM_W:0]          sum_x;
    logic                    add_ovf, smaller, larger, accept, last;

    function automatic logic [SUM_W-1:0] ext_fn(input logic [DATA_W-1:0] d);
        if (SIGNED)
            return SUM_W'($signed(d));
        else
            return SUM_W'(d);
    endfunction

    // On signed overflow both operands share a sign, so acc's sign picks the rail.
    function automatic logic [SUM_W-1:0] sat_fn(input logic             ovf,
                                                input logic             neg,
                                                input logic [SUM_W-1:0] wrapped);
        if (!ovf)
            return wrapped;
        else if (!SIGNED)
            return '1;
        else if (neg)
            return {1'b1, {(SUM_W-1){1'b0}}};
        else
            return {1'b0, {(SUM_W-1){1'b1}}};
    endfunction

    always_comb begin
        ext     = ext_fn(data_i);
        ext_s   = $signed(ext);
        acc_s   = $signed(acc);
        sum_x   = {1'b0, acc} + {1'b0, ext};
        add_ovf = SIGNED ? ((acc[SUM_W-1] == ext[SUM_W-1]) && (sum_x[SUM_W-1] != acc[SUM_W-1]))
                         : sum_x[SUM_W];
        smaller = SIGNED ? (ext_s < acc_s) : (ext < acc);
        larger  = SIGNED ? (ext_s > acc_s) : (ext > acc);
        accept  = (state == S_RUN) && valid_i;
        last    = (cnt == n_q - CNT_W'(1));

        acc_nxt = acc;
        ovf_nxt = ovf_q;
        case (mode_q)
            M_WRAP: begin
                acc_nxt = sum_x[SUM_W-1:0];
                ovf_nxt = ovf_q | add_ovf;
            end
            M_SAT: begin
                acc_nxt = sat_fn(add_ovf, acc[SUM_W-1], sum_x[SUM_W-1:0]);
                ovf_nxt = ovf_q | add_ovf;
            end
            M_MIN:   acc_nxt = ((cnt == '0) || smaller) ? ext : acc;
            M_MAX:   acc_nxt = ((cnt == '0) || larger)  ? ext : acc;
            default: acc_nxt = acc;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_i) state_nxt = (n_i != '0) ? S_RUN : S_DONE;
            S_RUN:   if (accept && last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they align with state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= S_IDLE;
            ready_o    <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            n_q        <= '0;
            mode_q     <= '0;
            cnt        <= '0;
            acc        <= '0;
            ovf_q      <= 1'b0;
            result_o   <= '0;
            overflow_o <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_o <= (state_nxt == S_RUN);
            busy_o  <= (state_nxt != S_IDLE);
            done_o  <= (state_nxt == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        if (n_i != '0) begin
                            n_q    <= n_i;
                            mode_q <= mode_i;
                            cnt    <= '0;
                            acc    <= '0;
                            ovf_q  <= 1'b0;
                        end else begin
                            result_o   <= '0;
                            overflow_o <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        cnt   <= cnt + CNT_W'(1);
                        acc   <= acc_nxt;
                        ovf_q <= ovf_nxt;
                        if (last) begin
                            result_o   <= acc_nxt;
                            overflow_o <= ovf_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_accum.sv
// Directed bench for stream_accum: three instances (default, 8-bit sum, signed)
// share one stimulus stream; each test checks the instance it targets.
module tb_stream_accum;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] n_i;
    logic [1:0] mode;
    logic [7:0] data;
    logic       valid;

    logic        a_ready, a_busy, a_done, a_ovf;
    logic [15:0] a_result;
    logic        b_ready, b_busy, b_done, b_ovf;
    logic [7:0]  b_result;
    logic        c_ready, c_busy, c_done, c_ovf;
    logic [15:0] c_result;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic [7:0] smp [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (a_done) begin done_cnt++; done_cyc = cyc; end

    stream_accum u_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .n_i(n_i), .mode_i(mode),
        .data_i(data), .valid_i(valid), .ready_o(a_ready), .busy_o(a_busy),
        .done_o(a_done), .result_o(a_result), .overflow_o(a_ovf));

    stream_accum #(.SUM_W(8)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .n_i(n_i), .mode_i(mode),
        .data_i(data), .valid_i(valid), .ready_o(b_ready), .busy_o(b_busy),
        .done_o(b_done), .result_o(b_result), .overflow_o(b_ovf));

    stream_accum #(.SIGNED(1'b1)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .n_i(n_i), .mode_i(mode),
        .data_i(data), .valid_i(valid), .ready_o(c_ready), .busy_o(c_busy),
        .done_o(c_done), .result_o(c_result), .overflow_o(c_ovf));

    // Runs one command from smp[]; gap = idle cycles between samples, poke = sample
    // index during which a stray start with n=2 is driven (-1 for none).
    task automatic do_cmd(input int n, input logic [1:0] md, input int gap, input int poke,
                          output int lat, output int ndone);
        int t0, d0;
        @(negedge clk);
        start = 1'b1; n_i = 8'(n); mode = md; valid = 1'b0;
        @(posedge clk); #1;
        t0 = cyc; d0 = done_cnt;
        for (int j = 0; j < n; j++) begin
            if (j > 0)
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk); start = 1'b0; valid = 1'b0; data = 8'hAA;
                    @(posedge clk);
                end
            @(negedge clk);
            start = (j == poke);
            if (j == poke) n_i = 8'd2;
            valid = 1'b1; data = smp[j];
            @(posedge clk);
        end
        @(negedge clk); start = 1'b0; valid = 1'b0; data = 8'h00;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (done_cnt != d0) begin lat = done_cyc - t0 + 1; break; end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        #1;
        ndone = done_cnt - d0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; n_i = '0; mode = '0; data = '0; valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", a_ready); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", a_busy); end
        n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", a_done); end
        n_checks++; if (a_result !== 16'd0) begin n_fail++; $display("FAIL reset_result got %0d want 0", a_result); end
        n_checks++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", a_ovf); end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_sum();
        int lat, nd;
        smp = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd0, 8'd0, 8'd0, 8'd0};
        do_cmd(4, 2'd0, 0, -1, lat, nd);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL sum_latency got %0d want 5", lat); end
        n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL sum_done_pulses got %0d want 1", nd); end
        n_checks++; if (a_result !== 16'd100) begin n_fail++; $display("FAIL sum_result got %0d want 100", a_result); end
        n_checks++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL sum_ovf got %b want 0", a_ovf); end
        n_checks++; if ({a_busy, a_ready} !== 2'b00) begin n_fail++; $display("FAIL sum_idle_flags got %b want 00", {a_busy, a_ready}); end
    endtask

    task automatic test_stall();
        int lat, nd;
        smp = '{8'd5, 8'd6, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        do_cmd(3, 2'd0, 2, -1, lat, nd);
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL stall_latency got %0d want 8", lat); end
        n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL stall_done_pulses got %0d want 1", nd); end
        n_checks++; if (a_result !== 16'd18) begin n_fail++; $display("FAIL stall_result got %0d want 18", a_result); end
    endtask

    task automatic test_wrap_sat();
        int lat, nd;
        smp = '{8'd200, 8'd100, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        do_cmd(3, 2'd0, 0, -1, lat, nd);
        n_checks++; if (b_result !== 8'd54) begin n_fail++; $display("FAIL wrap8_result got %0d want 54", b_result); end
        n_checks++; if (b_ovf !== 1'b1) begin n_fail++; $display("FAIL wrap8_ovf got %b want 1", b_ovf); end
        n_checks++; if (a_result !== 16'd310) begin n_fail++; $display("FAIL wrap16_result got %0d want 310", a_result); end
        n_checks++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL wrap16_ovf got %b want 0", a_ovf); end
        do_cmd(3, 2'd3, 0, -1, lat, nd);
        n_checks++; if (b_result !== 8'd255) begin n_fail++; $display("FAIL sat8_result got %0d want 255", b_result); end
        n_checks++; if (b_ovf !== 1'b1) begin n_fail++; $display("FAIL sat8_ovf got %b want 1", b_ovf); end
        n_checks++; if (a_result !== 16'd310) begin n_fail++; $display("FAIL sat16_result got %0d want 310", a_result); end
    endtask

    task automatic test_zero_n();
        int lat, nd;
        do_cmd(0, 2'd0, 0, -1, lat, nd);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL zero_latency got %0d want 1", lat); end
        n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL zero_done_pulses got %0d want 1", nd); end
        n_checks++; if (a_result !== 16'd0) begin n_fail++; $display("FAIL zero_result got %0d want 0", a_result); end
        n_checks++; if (b_ovf !== 1'b0) begin n_fail++; $display("FAIL zero_ovf_cleared got %b want 0", b_ovf); end
    endtask

    task automatic test_minmax();
        int lat, nd;
        smp = '{8'hFD, 8'h07, 8'h80, 8'h05, 8'd0, 8'd0, 8'd0, 8'd0};
        do_cmd(4, 2'd1, 0, -1, lat, nd);
        n_checks++; if (c_result !== 16'hFF80) begin n_fail++; $display("FAIL smin_result got %h want ff80", c_result); end
        n_checks++; if (c_ovf !== 1'b0) begin n_fail++; $display("FAIL smin_ovf got %b want 0", c_ovf); end
        n_checks++; if (a_result !== 16'd5) begin n_fail++; $display("FAIL umin_result got %0d want 5", a_result); end
        do_cmd(4, 2'd2, 0, -1, lat, nd);
        n_checks++; if (c_result !== 16'd7) begin n_fail++; $display("FAIL smax_result got %0d want 7", c_result); end
        n_checks++; if (a_result !== 16'd253) begin n_fail++; $display("FAIL umax_result got %0d want 253", a_result); end
    endtask

    task automatic test_start_in_run();
        int lat, nd;
        smp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
        do_cmd(4, 2'd0, 0, 1, lat, nd);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL run_start_latency got %0d want 5", lat); end
        n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL run_start_pulses got %0d want 1", nd); end
        n_checks++; if (a_result !== 16'd10) begin n_fail++; $display("FAIL run_start_result got %0d want 10", a_result); end
    endtask

    task automatic test_reset_mid();
        int d0, lat, nd;
        @(negedge clk); start = 1'b1; n_i = 8'd5; mode = 2'd0; valid = 1'b0;
        @(negedge clk); start = 1'b0; valid = 1'b1; data = 8'd9;
        @(negedge clk); data = 8'd9;
        @(negedge clk); valid = 1'b0;
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({a_ready, a_busy, a_done, a_ovf} !== 4'b0000) begin n_fail++; $display("FAIL abort_flags got %b want 0000", {a_ready, a_busy, a_done, a_ovf}); end
        n_checks++; if (a_result !== 16'd0) begin n_fail++; $display("FAIL abort_result got %0d want 0", a_result); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        n_checks++; if (done_cnt !== d0) begin n_fail++; $display("FAIL abort_no_done got %0d pulses want 0", done_cnt - d0); end
        smp = '{8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        do_cmd(2, 2'd0, 0, -1, lat, nd);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL after_abort_latency got %0d want 3", lat); end
        n_checks++; if (a_result !== 16'd7) begin n_fail++; $display("FAIL after_abort_result got %0d want 7", a_result); end
    endtask

    initial begin
        test_reset();
        test_sum();
        test_stall();
        test_wrap_sat();
        test_zero_n();
        test_minmax();
        test_start_in_run();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
